// File: rtl/rwm_pkg.sv
// Shared definitions for the rwm frame buffer: FSM states, default geometry
// and the constant log2 helper used to size the pointer.
package rwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CLEAR = 2'd3
  } rwm_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 480;

  // Never returns 0 so a one-word frame still gets a legal 1-bit pointer.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rwm_sp_ram.sv
// Single-port synchronous RAM: registered read with its own enable, so the
// read register doubles as the frame buffer's output data register.
module rwm_sp_ram
  import rwm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/rwm_frame_buf.sv
// Single-frame pixel store: streams a whole frame in (WRITE), out (READ) or
// fills it with CLEAR_VAL (CLEAR) under a one-shot command, abortable at any time.
module rwm_frame_buf
  import rwm_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                WIDTH     = DEF_WIDTH,
  parameter int                HEIGHT    = DEF_HEIGHT,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  localparam int               DEPTH     = WIDTH * HEIGHT,
  localparam int               ADDR_W    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rw,
  input  logic              clear,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              done,
  output logic              busy
);

  // Handshakes: a word moves on a port in every cycle where valid and ready
  // are both high; a producer holds valid and data stable until ready.

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rwm_state_e        state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              all_issued, all_issued_d;
  logic              out_valid_d;
  logic              done_d;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              issue, out_hs;

  assign busy     = (state != IDLE);
  assign in_ready = (state == WRITE);
  assign out_data = out_valid ? ram_rdata : '0;
  assign out_hs   = out_valid && out_ready;
  // At most one word in flight: reissue only when the output slot frees up.
  assign issue    = (state == READ) && (!out_valid || out_ready) && !all_issued;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      all_issued <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      all_issued <= all_issued_d;
      out_valid  <= out_valid_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    all_issued_d = all_issued;
    out_valid_d  = out_valid;
    done_d       = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_wdata    = in_data;
    case (state)
      IDLE: begin
        ptr_d        = '0;
        all_issued_d = 1'b0;
        out_valid_d  = 1'b0;
        if (enable) begin
          if (clear)   state_d = CLEAR;
          else if (rw) state_d = WRITE;
          else         state_d = READ;
        end
      end
      WRITE: begin
        if (in_valid) begin
          ram_we = 1'b1;
          if (ptr == LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end
      end
      READ: begin
        if (out_hs) out_valid_d = 1'b0;
        if (issue) begin
          ram_re      = 1'b1;
          out_valid_d = 1'b1;
          if (ptr == LAST) all_issued_d = 1'b1;
          else             ptr_d = ptr + 1'b1;
        end
        // all_issued with a handshake means the final word just left.
        if (out_hs && all_issued) begin
          state_d      = IDLE;
          ptr_d        = '0;
          all_issued_d = 1'b0;
          out_valid_d  = 1'b0;
          done_d       = 1'b1;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = CLEAR_VAL;
        if (ptr == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a coinciding final beat.
    if (abort && state != IDLE) begin
      state_d      = IDLE;
      ptr_d        = '0;
      all_issued_d = 1'b0;
      out_valid_d  = 1'b0;
      done_d       = 1'b0;
      ram_we       = 1'b0;
    end
  end

  rwm_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ptr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_rwm_frame_buf.sv
// Randomised bench for rwm_frame_buf on a 4x3 frame: an array model of the
// frame plus an expected-data queue for read-back.
module tb_rwm_frame_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, rw, clear, abort;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          done, busy;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] wdat [DEPTH];
  logic [DW-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  rwm_frame_buf #(
    .DATA_W    (DW),
    .WIDTH     (4),
    .HEIGHT    (3),
    .CLEAR_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rw        (rw),
    .clear     (clear),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic junk_cmd();
    enable = 1'($urandom_range(0, 1));
    rw     = 1'($urandom_range(0, 1));
    clear  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_check(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  // gap_mode: 0 = in_valid low every third cycle, 1 = random gaps, 2 = none
  task automatic do_write(input int abort_at, input int gap_mode, input bit chain_read);
    int  i, c;
    bit  v;
    @(negedge clk);
    enable = 1'b1; rw = 1'b1; clear = 1'b0;
    @(posedge clk);
    i = 0; c = 0;
    while (i < DEPTH) begin
      @(negedge clk);
      c++;
      if (c > 200) begin
        check("wr_timeout", i, DEPTH);
        in_valid = 1'b0; enable = 1'b0;
        return;
      end
      junk_cmd();
      check("wr_busy", busy, 1);
      check("wr_in_ready", in_ready, 1);
      check("wr_done_early", done, 0);
      case (gap_mode)
        0:       v = (c % 3) != 0;
        1:       v = $urandom_range(0, 3) != 0;
        default: v = 1'b1;
      endcase
      if (i == abort_at) v = 1'b1;
      in_valid = v;
      in_data  = v ? wdat[i] : DW'($urandom);
      abort    = (i == abort_at);
      @(posedge clk);
      if (abort) begin
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; enable = 1'b0;
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        return;
      end
      if (v) begin
        model_mem[i] = wdat[i];
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    enable = chain_read; rw = 1'b0; clear = 1'b0;
    check("wr_done", done, 1);
    check("wr_done_busy", busy, 0);
    check("wr_done_in_ready", in_ready, 0);
  endtask

  // rdy_mode: 0 = random out_ready, 1 = always ready. reset_at > 0 pulls rst_n
  // low in that cycle of the read.
  task automatic do_read(input bit skip_cmd, input bit rdy_mode, input int reset_at);
    int            got, cyc, first_v;
    bit            prev_stall;
    logic [DW-1:0] prev_d;
    exp_q.delete();
    for (int j = 0; j < DEPTH; j++) exp_q.push_back(model_mem[j]);
    if (!skip_cmd) begin
      @(negedge clk);
      enable = 1'b1; rw = 1'b0; clear = 1'b0;
    end
    @(posedge clk);
    got = 0; cyc = 0; first_v = 0; prev_stall = 1'b0; prev_d = '0;
    while (got < DEPTH) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin
        check("rd_timeout", got, DEPTH);
        enable = 1'b0; out_ready = 1'b0;
        return;
      end
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        enable = 1'b0; out_ready = 1'b0;
        #1;
        check_reset_outputs("rst_mid_read");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      junk_cmd();
      out_ready = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
      check("rd_busy", busy, 1);
      check("rd_done_early", done, 0);
      if (out_valid && first_v == 0) begin
        first_v = cyc;
        check("rd_first_valid_cyc", cyc, 2);
      end
      if (prev_stall) begin
        check("rd_stall_valid", out_valid, 1);
        check("rd_stall_data", out_data, prev_d);
      end
      if (out_valid && out_ready) begin
        check("rd_data", out_data, exp_q.pop_front());
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      @(posedge clk);
    end
    if (rdy_mode) check("rd_last_cyc", cyc, DEPTH + 1);
    @(negedge clk);
    enable = 1'b0; out_ready = 1'b0;
    check("rd_done", done, 1);
    check("rd_done_busy", busy, 0);
    check("rd_done_out_valid", out_valid, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    enable = 1'b1; rw = 1'b1; clear = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= DEPTH; c++) begin
      @(negedge clk);
      junk_cmd();
      check("clr_busy", busy, 1);
      check("clr_done_early", done, 0);
      @(posedge clk);
    end
    @(negedge clk);
    enable = 1'b0; clear = 1'b0;
    check("clr_done", done, 1);
    check("clr_done_busy", busy, 0);
    for (int j = 0; j < DEPTH; j++) model_mem[j] = 8'h00;
  endtask

  task automatic rand_frame();
    for (int j = 0; j < DEPTH; j++) wdat[j] = DW'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; rw = 1'b0; clear = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_check(2);

    // Fixed ramp with periodic gaps, then read back under random backpressure.
    for (int j = 0; j < DEPTH; j++) wdat[j] = 8'h10 + DW'(j);
    do_write(-1, 0, 1'b0);
    idle_check(1);
    do_read(1'b0, 1'b0, 0);
    idle_check(1);

    // Clear beats write when both are requested.
    do_clear();
    idle_check(1);
    do_read(1'b0, 1'b0, 0);

    // Abort mid-frame: only beats before the abort land.
    rand_frame();
    do_write(-1, 1, 1'b0);
    rand_frame();
    do_write(5, 1, 1'b0);
    idle_check(3);
    do_read(1'b0, 1'b0, 0);

    // Abort on the final beat suppresses done and that write.
    rand_frame();
    do_write(DEPTH - 1, 2, 1'b0);
    idle_check(2);
    do_read(1'b0, 1'b1, 0);

    // Reset mid-read; memory survives reset.
    do_read(1'b0, 1'b0, 5);
    idle_check(2);
    do_read(1'b0, 1'b0, 0);

    // Write followed by a read enabled in the done cycle.
    rand_frame();
    do_write(-1, 2, 1'b1);
    do_read(1'b1, 1'b1, 0);
    idle_check(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
